// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types and sizes for the register-file writeback controller.
package regfile_ctrl_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  // Requester slots on the writeback arbiter.
  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_wb_ctrl_arb.sv
// Two-requester round-robin arbiter for the register-file write port.
// Grant is combinational; the priority pointer moves only when a grant
// is issued, and a grant is only ever given to an active request.
module wb_rr_arb
  import regfile_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // High when the mem requester wins a tie; mem is favoured out of reset.
  logic mem_pri;

  // Pick one requester: mem on a tie when it holds priority, else alu.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[SRC_MEM] && (mem_pri || !req[SRC_ALU])) begin
        gnt[SRC_MEM] = 1'b1;
      end else if (req[SRC_ALU]) begin
        gnt[SRC_ALU] = 1'b1;
      end
    end
  end

  // Hand priority to the other side after every transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_pri <= 1'b1;
    end else if (|gnt) begin
      mem_pri <= gnt[SRC_ALU];
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller: sweeps the register file to zero
// after reset, then arbitrates ALU and load writebacks onto the single
// write port and tracks per-register busy bits for decode hazard checks.
module regfile_wb_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_wr,
  input  logic [DATA_W-1:0]     alu_wd,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_wr,
  input  logic [DATA_W-1:0]     mem_wd,
  output logic                  mem_ready,
  output logic                  rf_wren,
  output logic [REG_ADDR_W-1:0] rf_wr,
  output logic [DATA_W-1:0]     rf_wd,
  input  logic                  rsv_valid,
  input  logic [REG_ADDR_W-1:0] rsv_reg,
  input  logic [REG_ADDR_W-1:0] chk_a,
  input  logic [REG_ADDR_W-1:0] chk_b,
  output logic                  hazard,
  output logic                  init_done
);

  state_t                  state;
  logic [REG_ADDR_W-1:0]   cnt;
  logic [REG_COUNT-1:0]    busy;
  logic [REG_COUNT-1:0]    busy_nxt;
  logic [1:0]              gnt;
  logic                    run;
  logic                    xfer;
  logic [REG_ADDR_W-1:0]   sel_wr;
  logic [DATA_W-1:0]       sel_wd;

  assign run = (state == RUN);

  wb_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .req   ({mem_valid, alu_valid}),
    .gnt   (gnt)
  );

  assign alu_ready = gnt[SRC_ALU];
  assign mem_ready = gnt[SRC_MEM];
  assign xfer      = |gnt;

  // Route the granted source onto the write path.
  always_comb begin
    sel_wr = alu_wr;
    sel_wd = alu_wd;
    if (gnt[SRC_MEM]) begin
      sel_wr = mem_wr;
      sel_wd = mem_wd;
    end
  end

  // Operands are reported busy for the whole sweep so decode stalls.
  assign hazard = !run || busy[chk_a] || busy[chk_b];

  // Next busy vector: writeback clears first so a same-cycle reservation wins.
  always_comb begin
    busy_nxt = busy;
    if (xfer && (sel_wr != '0)) begin
      busy_nxt[sel_wr] = 1'b0;
    end
    if (run && rsv_valid && (rsv_reg != '0)) begin
      busy_nxt[rsv_reg] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Busy scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Control FSM and registered write port. The sweep counter wraps from
  // 31 to 0, which marks the cycle that hands over to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET) begin
        state <= CLEAR;
      end else begin
        state <= RUN;
      end
      cnt       <= REG_ADDR_W'(1);
      rf_wren   <= 1'b0;
      rf_wr     <= '0;
      rf_wd     <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (cnt != '0) begin
            rf_wren <= 1'b1;
            rf_wr   <= cnt;
            rf_wd   <= '0;
            cnt     <= cnt + REG_ADDR_W'(1);
          end else begin
            rf_wren   <= 1'b0;
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          init_done <= 1'b1;
          rf_wren   <= xfer && (sel_wr != '0);
          if (xfer) begin
            rf_wr <= sel_wr;
            rf_wd <= sel_wd;
          end
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed scenarios followed by
// randomized writeback/reservation traffic against a behavioural model.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid, rsv_valid;
  logic [4:0]  alu_wr, mem_wr, rsv_reg, chk_a, chk_b;
  logic [31:0] alu_wd, mem_wd;
  logic        alu_ready, mem_ready, rf_wren, hazard, init_done;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.CLEAR_ON_RESET(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_wr    (alu_wr),
    .alu_wd    (alu_wd),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_wr    (mem_wr),
    .mem_wd    (mem_wd),
    .mem_ready (mem_ready),
    .rf_wren   (rf_wren),
    .rf_wr     (rf_wr),
    .rf_wd     (rf_wd),
    .rsv_valid (rsv_valid),
    .rsv_reg   (rsv_reg),
    .chk_a     (chk_a),
    .chk_b     (chk_b),
    .hazard    (hazard),
    .init_done (init_done)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: which registers have an outstanding reservation,
  // and which source wins the next tie.
  bit busy_m [32];
  bit mem_turn;
  bit took_alu, took_mem;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One RUN-mode clock: check combinational outputs, advance the model,
  // then check the registered write port one edge later.
  task automatic step();
    bit          g_alu, g_mem, exp_wren;
    logic [4:0]  w;
    logic [31:0] d;
    #1;
    g_mem = mem_valid && (mem_turn || !alu_valid);
    g_alu = alu_valid && !g_mem;
    chk("alu_ready", alu_ready, g_alu);
    chk("mem_ready", mem_ready, g_mem);
    chk("hazard", hazard, busy_m[chk_a] || busy_m[chk_b]);
    w = g_mem ? mem_wr : alu_wr;
    d = g_mem ? mem_wd : alu_wd;
    exp_wren = (g_alu || g_mem) && (w != 0);
    @(posedge clk);
    if (g_alu || g_mem) begin
      mem_turn = g_alu;
      if (w != 0) busy_m[w] = 1'b0;
    end
    if (rsv_valid && rsv_reg != 0) busy_m[rsv_reg] = 1'b1;
    took_alu = g_alu;
    took_mem = g_mem;
    @(negedge clk);
    chk("rf_wren", rf_wren, exp_wren);
    if (exp_wren) begin
      chk("rf_wr", rf_wr, w);
      chk("rf_wd", rf_wd, d);
    end
    chk("init_done", init_done, 1'b1);
  endtask

  int exp_seq [4] = '{6, 5, 6, 5};

  initial begin
    rst_n = 1'b0;
    alu_valid = 0; alu_wr = 0; alu_wd = 0;
    mem_valid = 0; mem_wr = 0; mem_wd = 0;
    rsv_valid = 0; rsv_reg = 0; chk_a = 0; chk_b = 0;
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    mem_turn = 1'b1;

    // Reset state
    #2;
    chk("rst_rf_wren", rf_wren, 0);
    chk("rst_rf_wr", rf_wr, 0);
    chk("rst_rf_wd", rf_wd, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_hazard", hazard, 1);

    // Sweep-clear: requests and reservations must be ignored throughout
    @(negedge clk);
    rst_n = 1'b1;
    alu_valid = 1; alu_wr = 2; mem_valid = 1; mem_wr = 3;
    rsv_valid = 1; rsv_reg = 3; chk_a = 3;
    for (int k = 1; k <= 31; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("clr_wren", rf_wren, 1);
      chk("clr_wr", rf_wr, k);
      chk("clr_wd", rf_wd, 0);
      chk("clr_hazard", hazard, 1);
      chk("clr_init_done", init_done, 0);
      chk("clr_alu_ready", alu_ready, 0);
      chk("clr_mem_ready", mem_ready, 0);
    end
    alu_valid = 0; mem_valid = 0; rsv_valid = 0;
    @(posedge clk);
    @(negedge clk);
    chk("run_init_done", init_done, 1);
    chk("run_wren", rf_wren, 0);
    chk("run_hazard_clean", hazard, 0);

    // Round-robin on continuous contention, mem first
    alu_valid = 1; alu_wr = 5; alu_wd = 32'h0000_5555;
    mem_valid = 1; mem_wr = 6; mem_wd = 32'h0000_6666;
    chk_a = 0; chk_b = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_seq", rf_wr, exp_seq[i]);
    end
    alu_valid = 0; mem_valid = 0;

    // Reservation then load writeback clears it
    rsv_valid = 1; rsv_reg = 9; chk_a = 9;
    step();
    rsv_valid = 0;
    mem_valid = 1; mem_wr = 9; mem_wd = 32'hDEAD_BEEF;
    #1 chk("rsv9_hazard", hazard, 1);
    step();
    chk("ld9_wr", rf_wr, 9);
    chk("ld9_wd", rf_wd, 32'hDEAD_BEEF);
    mem_valid = 0;
    #1 chk("ld9_hazard_clr", hazard, 0);
    step();

    // Write to r0: accepted, no port write, busy untouched
    rsv_valid = 1; rsv_reg = 4; chk_b = 4;
    step();
    rsv_valid = 0;
    alu_valid = 1; alu_wr = 0; alu_wd = 32'h1234_5678;
    #1 chk("r0_ready", alu_ready, 1);
    step();
    chk("r0_no_wren", rf_wren, 0);
    alu_valid = 0;
    #1 chk("r0_hazard_kept", hazard, 1);
    step();

    // Same-cycle reserve and writeback of r7: reservation wins
    rsv_valid = 1; rsv_reg = 7;
    step();
    alu_valid = 1; alu_wr = 7; alu_wd = 32'h0000_0077;
    step();
    alu_valid = 0; rsv_valid = 0; chk_a = 7; chk_b = 0;
    #1 chk("r7_still_busy", hazard, 1);
    step();

    // Randomized traffic; sources hold their request until granted
    for (int n = 0; n < 400; n++) begin
      if (!alu_valid || took_alu) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_wr    = 5'($urandom_range(0, 9));
        alu_wd    = $urandom();
      end
      if (!mem_valid || took_mem) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_wr    = 5'($urandom_range(0, 31));
        mem_wd    = $urandom();
      end
      rsv_valid = ($urandom_range(0, 3) == 0);
      rsv_reg   = 5'($urandom_range(0, 9));
      chk_a     = 5'($urandom_range(0, 9));
      chk_b     = 5'($urandom_range(0, 31));
      step();
    end

    // Reset in RUN with a request pending: nothing is written
    alu_valid = 1; alu_wr = 3; alu_wd = 32'hCAFE_0003;
    mem_valid = 0; rsv_valid = 0;
    #1 rst_n = 1'b0;
    #1 chk("rst_run_wren", rf_wren, 0);
    chk("rst_run_ready", alu_ready, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_run_hold_wren", rf_wren, 0);
    chk("rst_run_init_done", init_done, 0);

    // Restart the sweep, interrupt it at register 15, and restart again
    rst_n = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("clr2_wr", rf_wr, k);
      chk("clr2_ready", alu_ready, 0);
    end
    #1 rst_n = 1'b0;
    #1 chk("mid_clr_wren", rf_wren, 0);
    chk("mid_clr_wr", rf_wr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("restart_wren", rf_wren, 1);
    chk("restart_wr", rf_wr, 1);
    chk("restart_wd", rf_wd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 SHALL have parameter: CLEAR_ON_RESET, 1, when 1 sweep-clear registers 1..31 after reset; when 0 enter RUN directly.
REQ-002 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: alu_valid in 1, alu_wr in 5, alu_wd in 32, alu_ready out 1; ALU writeback request.
REQ-005 SHALL have ports: mem_valid in 1, mem_wr in 5, mem_wd in 32, mem_ready out 1; load writeback request.
REQ-006 SHALL have ports: rf_wren out 1, rf_wr out 5, rf_wd out 32; drive the single register-file write port.
REQ-007 SHALL have ports: rsv_valid in 1, rsv_reg in 5; issue-stage reservation of a destination register.
REQ-008 SHALL have ports: chk_a in 5, chk_b in 5, hazard out 1; decode-stage source-operand busy check.
REQ-009 SHALL have port: init_done out 1, high once in RUN.

Function
REQ-010 SHALL implement FSM states CLEAR and RUN; reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
REQ-011 In CLEAR, SHALL register rf_wren=1, rf_wr=cnt, rf_wd=0 for cnt=1..31 on consecutive cycles (31 cycles), then enter RUN.
REQ-012 In CLEAR, SHALL hold alu_ready=0, mem_ready=0, hazard=1, init_done=0, and ignore rsv_valid.
REQ-013 In RUN, SHALL grant at most one source per cycle; ready asserted combinationally only to the granted valid source.
REQ-014 Arbitration SHALL be round-robin: when both valid, the source not granted last wins; after reset mem has priority.
REQ-015 Transfer occurs on valid&&ready; last-grant pointer updates only on transfer.
REQ-016 On transfer, SHALL register rf_wren=(wr!=0), rf_wr=wr, rf_wd=wd on the next edge (1-cycle latency); otherwise rf_wren=0.
REQ-017 Writes to register 0 SHALL be accepted (ready high, busy unaffected) but never drive rf_wren.
REQ-018 Sources SHALL hold wr/wd stable while valid&&!ready; block performs no buffering.
REQ-019 SHALL keep busy[31:1]; busy[0] permanently 0.
REQ-020 rsv_valid with rsv_reg!=0 in RUN SHALL set busy[rsv_reg] at next edge.
REQ-021 A transfer with wr!=0 SHALL clear busy[wr] at next edge.
REQ-022 Same-cycle set and clear of same register SHALL leave it set (new reservation wins).
REQ-023 Reserving an already-busy register SHALL leave it busy; first writeback clears it (issuer must stall instead).
REQ-024 In RUN, hazard SHALL be combinational busy[chk_a] | busy[chk_b].
REQ-025 rf_wd SHALL be an unmodified 32-bit copy of the granted wd; no arithmetic on data.

Reset
REQ-026 Asserting rst_n low SHALL immediately force: rf_wren=0, rf_wr=0, rf_wd=0, busy=0, cnt=1, pointer=mem-priority, init_done=0.
REQ-027 Reset during CLEAR SHALL restart the sweep from register 1; reset during RUN SHALL discard in-flight grant (no write issued).
REQ-028 Deassertion SHALL be honored on the first rising clk edge after rst_n goes high.

Structure
REQ-029 Package regfile_ctrl_pkg SHALL hold state enum (CLEAR, RUN), REG_COUNT=32, REG_ADDR_W=5, DATA_W=32.
REQ-030 Round-robin grant logic SHALL be a sub-module wb_rr_arb (2 requesters, grant vector, pointer update on transfer).
REQ-031 Scoreboard and FSM SHALL remain in regfile_wb_ctrl.

Verification
REQ-032 Reset release, CLEAR_ON_RESET=1 -> rf_wr steps 1..31 with rf_wd=0, rf_wren high 31 cycles, init_done rises cycle 32, hazard=1 throughout.
REQ-033 RUN, alu and mem both valid 4 cycles (alu_wr=5, mem_wr=6) -> grants mem,alu,mem,alu; rf_wr 6,5,6,5 one cycle later.
REQ-034 rsv_valid rsv_reg=9; chk_a=9 -> hazard=1 next cycle; mem transfer wr=9 wd=0xDEADBEEF -> rf write 9/0xDEADBEEF, hazard=0 following cycle.
REQ-035 alu transfer wr=0 wd=0x12345678 -> alu_ready=1, rf_wren stays 0, hazard unaffected.
REQ-036 Same cycle: rsv_reg=7 and alu transfer wr=7 with busy[7]=1 -> busy[7] remains 1.
REQ-037 rst_n low mid-CLEAR at cnt=15 -> rf_wren=0 immediately; after release sweep restarts at rf_wr=1.
